switch_allocator: RTL and testbench
===================================

# switch_allocator

Separable input-first round-robin switch allocator for one router. Each cycle it reads the switch requests, output ports and downstream VCs of all `PORT_NUM` input ports. It grants at most one VC per input port and at most one input port per output port. It drives each input port's `vc_sel`/`valid_sel` read interface and the crossbar select lines. Fairness comes from registered round-robin priority pointers. Downstream on/off flow control masks requests before arbitration.

## Interface
- `PORT_NUM`, default 5: router ports. Indices follow `port_t`: LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4.
- `VC_NUM`, default 2: VCs per port. `VC_SIZE = $clog2(VC_NUM)`.
- `PORT_SIZE`, default `$clog2(PORT_NUM)`: width of an input-port index.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-low.
- `switch_request_i`, in, [PORT_NUM][VC_NUM]: VC v of input i holds a flit ready for switch traversal.
- `out_port_i`, in, port_t [PORT_NUM][VC_NUM]: routed output port of each input VC.
- `downstream_vc_i`, in, VC_SIZE [PORT_NUM][VC_NUM]: VC allocated downstream for each input VC.
- `on_off_i`, in, [PORT_NUM][VC_NUM]: per output port, per downstream VC. 1 means the downstream buffer accepts flits.
- `valid_sel_o`, out, [PORT_NUM]: input port i is granted this cycle. Drives `valid_sel_i`.
- `vc_sel_o`, out, VC_SIZE [PORT_NUM]: granted VC of input i. Drives `vc_sel_i`.
- `xb_valid_o`, out, [PORT_NUM]: output port o is driven this cycle.
- `xb_sel_o`, out, PORT_SIZE [PORT_NUM]: input port connected to output o.

## Operation
- Eligibility: `elig[i][v] = switch_request_i[i][v] && on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]]`.
- Stage 1, per input i:
  - Round-robin over `elig[i]`, starting at `vc_ptr[i]`, ascending, wrapping modulo VC_NUM.
  - The winner is `w[i]`. `has[i]` is set if any VC is eligible.
- Stage 2, per output o:
  - Candidates are inputs with `has[i]` and `out_port_i[i][w[i]] == o`.
  - Round-robin over candidates, starting at `in_ptr[o]`, ascending, wrapping modulo PORT_NUM.
  - The winner is `g[o]`.
- Grant outputs:
  - `xb_valid_o[o]=1`, `xb_sel_o[o]=g[o]`.
  - `valid_sel_o[g[o]]=1`, `vc_sel_o[g[o]]=w[g[o]]`.
  - Ungranted inputs: `valid_sel_o=0`, `vc_sel_o=0`.
  - Ungranted outputs: `xb_valid_o=0`, `xb_sel_o=0`.
- Pointer update, on a granted pair only:
  - `in_ptr[o] <= (g[o]+1) mod PORT_NUM`.
  - `vc_ptr[g[o]] <= (w[g[o]]+1) mod VC_NUM`.
- Inputs that win stage 1 but lose stage 2 keep `vc_ptr` unchanged. Outputs with no grant keep `in_ptr` unchanged.
- Wrap arithmetic uses explicit compare-to-max. It is not power-of-two truncation, because PORT_NUM=5.
- Invariants, every cycle:
  - Each input is granted at most once.
  - Each output is granted at most once.
  - `valid_sel_o` popcount equals `xb_valid_o` popcount.
  - Every granted (i,v) had `elig=1`.
- A request whose downstream VC is off is never granted. It does not block other VCs of the same input.
- A request with `out_port_i == i` (u-turn) is arbitrated normally. There is no special case.

## Timing
- Grant outputs are combinational from inputs and registered pointers. Latency is 0 cycles, so the granted input reads and traverses in the same cycle.
- Pointers change on the rising edge after a grant. Priority rotation is visible from the next cycle.
- While `rst=0`:
  - All `vc_ptr=0`, all `in_ptr=0`.
  - `valid_sel_o`, `vc_sel_o`, `xb_valid_o`, `xb_sel_o` are forced to 0, independent of requests.
- Reset asserted mid-operation clears pointers immediately (asynchronous). Grants drop in the same cycle.
- After `rst` deasserts, the first edge behaves as from reset state.
- No grant is held across cycles. The requester re-requests every cycle until it is granted.

## Test plan
- **Reset:** `rst=0` with all `switch_request_i=1`, all `on_off_i=1` → all outputs 0. After release, port0 VC0 wins first, pointers at 0.
- **Output contention:** inputs 1,2,3 request output EAST (VC0, on). Over 3 cycles, `xb_sel_o[4]` = 1, 2, 3, then 1 again. Exactly one `valid_sel_o` high per cycle.
- **VC round-robin:** input 0, VC0 and VC1 both → NORTH, no contention. `vc_sel_o[0]` alternates 0,1,0,1.
- **Flow control:**
  - Input 2 VC0 → WEST with `on_off_i[3][dvc]=0`, and VC1 → SOUTH with on → only VC1 granted.
  - Set off on SOUTH too → `valid_sel_o[2]=0`, `vc_ptr` unchanged.
- **Parallel grants:** five inputs each to a distinct output → all five `valid_sel_o`=1 in one cycle, with `xb_sel_o` forming the matching permutation.
- **Mid-run reset:** pointers advanced to non-zero, assert `rst` asynchronously between edges → outputs drop at once. Post-release priority restarts at index 0.

Source files
------------

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator: per-input VC arbitration,
// then per-output input arbitration, with on/off masking and registered RR pointers.
package switch_allocator_pkg;
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;
endpackage

module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int unsigned PORT_NUM  = 5,
  parameter int unsigned VC_NUM    = 2,
  parameter int unsigned VC_SIZE   = $clog2(VC_NUM),
  parameter int unsigned PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          switch_request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]          out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          on_off_i,
  output logic  [PORT_NUM-1:0]                      valid_sel_o,
  output logic  [PORT_NUM-1:0][VC_SIZE-1:0]         vc_sel_o,
  output logic  [PORT_NUM-1:0]                      xb_valid_o,
  output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]       xb_sel_o
);

  logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
  logic [PORT_NUM-1:0]                has;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   win_vc;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  cand;      // [output][input]
  logic [PORT_NUM-1:0]                gnt_vld;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] gnt_in;
  logic [PORT_NUM-1:0]                in_gnt;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_ptr_q, vc_ptr_d;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] in_ptr_q, in_ptr_d;

  // Request masked by downstream on/off; out-of-range port codes are never eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (32'(out_port_i[i][v]) < PORT_NUM) begin
          elig[i][v] = switch_request_i[i][v] &&
                       on_off_i[PORT_SIZE'(out_port_i[i][v])][downstream_vc_i[i][v]];
        end
      end
    end
  end

  // Stage 1: round-robin VC pick per input starting at vc_ptr.
  always_comb begin : stage1
    logic [VC_SIZE-1:0] idx;
    has    = '0;
    win_vc = '0;
    idx    = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = vc_ptr_q[i];
      for (int k = 0; k < VC_NUM; k++) begin
        if (!has[i] && elig[i][idx]) begin
          has[i]    = 1'b1;
          win_vc[i] = idx;
        end
        idx = (idx == VC_SIZE'(VC_NUM - 1)) ? '0 : idx + VC_SIZE'(1);
      end
    end
  end

  always_comb begin
    cand = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        cand[o][i] = has[i] && (32'(out_port_i[i][win_vc[i]]) == 32'(o));
      end
    end
  end

  // Stage 2: round-robin input pick per output starting at in_ptr.
  always_comb begin : stage2
    logic [PORT_SIZE-1:0] idx;
    gnt_vld = '0;
    gnt_in  = '0;
    idx     = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      idx = in_ptr_q[o];
      for (int k = 0; k < PORT_NUM; k++) begin
        if (!gnt_vld[o] && cand[o][idx]) begin
          gnt_vld[o] = 1'b1;
          gnt_in[o]  = idx;
        end
        idx = (idx == PORT_SIZE'(PORT_NUM - 1)) ? '0 : idx + PORT_SIZE'(1);
      end
    end
  end

  // Grant outputs are combinational and forced low while reset is held.
  always_comb begin
    in_gnt      = '0;
    valid_sel_o = '0;
    vc_sel_o    = '0;
    xb_valid_o  = '0;
    xb_sel_o    = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (gnt_vld[o]) begin
        in_gnt[gnt_in[o]] = 1'b1;
      end
    end
    if (rst) begin
      xb_valid_o  = gnt_vld;
      xb_sel_o    = gnt_in;
      valid_sel_o = in_gnt;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (in_gnt[i]) begin
          vc_sel_o[i] = win_vc[i];
        end
      end
    end
  end

  // Pointers advance past the winner only for pairs that were actually granted.
  always_comb begin
    in_ptr_d = in_ptr_q;
    vc_ptr_d = vc_ptr_q;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (gnt_vld[o]) begin
        in_ptr_d[o] = (gnt_in[o] == PORT_SIZE'(PORT_NUM - 1)) ? '0
                                                              : gnt_in[o] + PORT_SIZE'(1);
      end
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      if (in_gnt[i]) begin
        vc_ptr_d[i] = (win_vc[i] == VC_SIZE'(VC_NUM - 1)) ? '0
                                                          : win_vc[i] + VC_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ptr_q <= '0;
      vc_ptr_q <= '0;
    end else begin
      in_ptr_q <= in_ptr_d;
      vc_ptr_q <= vc_ptr_d;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed scoreboard bench for switch_allocator: stimulus pushes hand-computed
// expected grants, a negedge monitor pops and compares them plus grant invariants.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  logic                   clk;
  logic                   rst;
  logic  [4:0][1:0]       sreq;
  port_t [4:0][1:0]       oport;
  logic  [4:0][1:0][0:0] dvc;
  logic  [4:0][1:0]       onoff;
  logic  [4:0]            vs;
  logic  [4:0][0:0]       vcs;
  logic  [4:0]            xv;
  logic  [4:0][2:0]       xs;

  typedef struct {
    string      name;
    logic [4:0] vs;
    logic [4:0] vc;
    logic [4:0] xv;
    logic [14:0] xs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  switch_allocator dut (
    .clk              (clk),
    .rst              (rst),
    .switch_request_i (sreq),
    .out_port_i       (oport),
    .downstream_vc_i  (dvc),
    .on_off_i         (onoff),
    .valid_sel_o      (vs),
    .vc_sel_o         (vcs),
    .xb_valid_o       (xv),
    .xb_sel_o         (xs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    sreq  = '0;
    dvc   = '0;
    onoff = '1;
    for (int i = 0; i < 5; i++) begin
      oport[i][0] = LOCAL;
      oport[i][1] = LOCAL;
    end
  endtask

  task automatic exp_push(input string n, input logic [4:0] e_vs, input logic [4:0] e_vc,
                          input logic [4:0] e_xv, input logic [14:0] e_xs);
    exp_t e;
    e.name = n;
    e.vs   = e_vs;
    e.vc   = e_vc;
    e.xv   = e_xv;
    e.xs   = e_xs;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b0;
    clear_in();
    exp_push("rst_pulse", 5'b0, 5'b0, 5'b0, 15'd0);
    next_cyc();
    rst = 1'b1;
  endtask

  // Monitor: one scoreboard entry per cycle, plus structural grant invariants.
  logic [29:0] act, req;
  logic [2:0]  m_op;
  logic        m_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e   = exp_q.pop_front();
      act = {vs, vcs, xv, xs};
      req = {e.vs, e.vc, e.xv, e.xs};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got vs=%b vc=%b xv=%b xs=%b, want vs=%b vc=%b xv=%b xs=%b",
                 e.name, vs, vcs, xv, xs, e.vs, e.vc, e.xv, e.xs);
      end
      checks++;
      if ($countones(vs) != $countones(xv)) begin
        errors++;
        $display("FAIL %s popcount: got vs=%b xv=%b, want equal counts", e.name, vs, xv);
      end
      for (int o = 0; o < 5; o++) begin
        if (xv[o]) begin
          checks++;
          if (!(xs[o] < 3'd5 && vs[xs[o]])) begin
            errors++;
            $display("FAIL %s xb_link o%0d: got xs=%0d vs=%b, want granted input", e.name, o, xs[o], vs);
          end
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (vs[i]) begin
          m_v  = vcs[i];
          m_op = oport[i][m_v];
          checks++;
          if (!(sreq[i][m_v] && m_op < 3'd5 && onoff[m_op][dvc[i][m_v]])) begin
            errors++;
            $display("FAIL %s elig in%0d: got grant vc%0d, want eligible VC", e.name, i, m_v);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    clear_in();

    // Reset held with every request and every downstream VC on.
    next_cyc();
    sreq = '1;
    for (int i = 0; i < 5; i++) begin
      oport[i][0] = EAST;
      oport[i][1] = EAST;
    end
    exp_push("rst_hold0", 5'b0, 5'b0, 5'b0, 15'd0);
    next_cyc();
    exp_push("rst_hold1", 5'b0, 5'b0, 5'b0, 15'd0);
    next_cyc();
    rst = 1'b1;
    exp_push("rel_first", 5'b00001, 5'b0, 5'b10000, 15'd0);
    next_cyc();
    exp_push("rel_second", 5'b00010, 5'b0, 5'b10000, {3'd1, 12'd0});

    // Output contention on EAST from inputs 1..3.
    do_reset();
    for (int i = 1; i < 4; i++) begin
      sreq[i][0]  = 1'b1;
      oport[i][0] = EAST;
    end
    exp_push("cont_c1", 5'b00010, 5'b0, 5'b10000, {3'd1, 12'd0});
    next_cyc();
    exp_push("cont_c2", 5'b00100, 5'b0, 5'b10000, {3'd2, 12'd0});
    next_cyc();
    exp_push("cont_c3", 5'b01000, 5'b0, 5'b10000, {3'd3, 12'd0});
    next_cyc();
    exp_push("cont_c4", 5'b00010, 5'b0, 5'b10000, {3'd1, 12'd0});

    // VC round-robin on input 0 towards NORTH.
    do_reset();
    sreq[0]     = 2'b11;
    oport[0][0] = NORTH;
    oport[0][1] = NORTH;
    dvc[0][1]   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cyc();
      exp_push($sformatf("vcrr_%0d", k), 5'b00001, (k % 2 == 1) ? 5'b00001 : 5'b00000,
               5'b00010, 15'd0);
    end

    // Flow control on input 2: VC0 to WEST/dvc0, VC1 to SOUTH/dvc1.
    do_reset();
    sreq[2]     = 2'b11;
    oport[2][0] = WEST;
    oport[2][1] = SOUTH;
    dvc[2][1]   = 1'b1;
    onoff[3][0] = 1'b0;
    exp_push("flow_west_off", 5'b00100, 5'b00100, 5'b00100, {3'd0, 3'd0, 3'd2, 3'd0, 3'd0});
    next_cyc();
    onoff[3][0] = 1'b1;
    exp_push("flow_both_on", 5'b00100, 5'b00000, 5'b01000, {3'd0, 3'd2, 3'd0, 3'd0, 3'd0});
    next_cyc();
    onoff[3][0] = 1'b0;
    onoff[2][1] = 1'b0;
    exp_push("flow_all_off", 5'b0, 5'b0, 5'b0, 15'd0);
    next_cyc();
    onoff = '1;
    exp_push("flow_ptr_kept", 5'b00100, 5'b00100, 5'b00100, {3'd0, 3'd0, 3'd2, 3'd0, 3'd0});

    // Parallel grants: a permutation, then all u-turns on VC1.
    do_reset();
    for (int i = 0; i < 5; i++) sreq[i][0] = 1'b1;
    oport[0][0] = NORTH;
    oport[1][0] = SOUTH;
    oport[2][0] = WEST;
    oport[3][0] = EAST;
    oport[4][0] = LOCAL;
    exp_push("par_perm", 5'b11111, 5'b0, 5'b11111, {3'd3, 3'd2, 3'd1, 3'd0, 3'd4});
    next_cyc();
    clear_in();
    for (int i = 0; i < 5; i++) sreq[i][1] = 1'b1;
    oport[0][1] = LOCAL;
    oport[1][1] = NORTH;
    oport[2][1] = SOUTH;
    oport[3][1] = WEST;
    oport[4][1] = EAST;
    exp_push("par_uturn", 5'b11111, 5'b11111, 5'b11111, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});

    // Advance pointers, then reset between edges.
    next_cyc();
    clear_in();
    sreq = '1;
    exp_push("adv_local", 5'b00010, 5'b0, 5'b00001, 15'd1);
    next_cyc();
    #2;
    rst = 1'b0;
    exp_push("mid_rst", 5'b0, 5'b0, 5'b0, 15'd0);
    next_cyc();
    rst = 1'b1;
    exp_push("post_rst0", 5'b00001, 5'b0, 5'b00001, 15'd0);
    next_cyc();
    exp_push("post_rst1", 5'b00010, 5'b0, 5'b00001, 15'd1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
